// File: rtl/dense_layer_seq.sv
// dense_layer_seq: fully-connected layer y[j] = act(sum_i x[i]*w[j][i] + b[j]) on one shared multiplier.
// Define DENSE_RELU_EN for a ReLU activation; otherwise the layer is linear.
module dense_layer_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int ACC_W = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_IN*WIDTH-1:0]        in_data,
    input  logic [N_IN*N_OUT*WIDTH-1:0]  w_data,
    input  logic [N_OUT*WIDTH-1:0]       b_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_OUT*WIDTH-1:0]       out_data,
    output logic                         busy
);
    localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
    localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

    generate
        if (ACC_W < 2 * WIDTH + $clog2(N_IN) + 1) begin : g_acc_chk
            $error("dense_layer_seq: ACC_W too small for WIDTH/N_IN");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;
    state_t state, state_n;

    logic [N_IN*WIDTH-1:0]       x_r;
    logic [N_IN*N_OUT*WIDTH-1:0] w_r;
    logic [N_OUT*WIDTH-1:0]      b_r, y_r, y_n;
    logic [IW-1:0]               i;
    logic [JW-1:0]               j;
    logic signed [ACC_W-1:0]     acc, sum, t;
    logic signed [WIDTH-1:0]     xi, wi, bj, sat, yv;
    logic signed [2*WIDTH-1:0]   prod;
    logic                        last_i, last_j;

    assign last_i    = i == IW'(N_IN - 1);
    assign last_j    = j == JW'(N_OUT - 1);
    assign in_ready  = state == IDLE && !rst;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_comb begin
        xi   = x_r[int'(i)*WIDTH +: WIDTH];
        wi   = w_r[(int'(j)*N_IN + int'(i))*WIDTH +: WIDTH];
        bj   = b_r[int'(j)*WIDTH +: WIDTH];
        prod = xi * wi;
        sum  = acc + (ACC_W'(bj) <<< FRAC);
        t    = sum >>> FRAC;
        sat  = t > MAXV ? MAXV[WIDTH-1:0] : t < MINV ? MINV[WIDTH-1:0] : t[WIDTH-1:0];
`ifdef DENSE_RELU_EN
        yv   = sat[WIDTH-1] ? '0 : sat;
`else
        yv   = sat;
`endif
        y_n  = y_r;
        y_n[int'(j)*WIDTH +: WIDTH] = yv;
        state_n = state == IDLE ? (in_valid ? MAC : IDLE)
                : state == MAC  ? (last_i ? FIN : MAC)
                : state == FIN  ? (last_j ? DONE : MAC)
                : (out_ready ? IDLE : DONE);
    end

    // out_data is only replaced when the final output lands, so it stays stable outside DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x_r      <= '0;
            w_r      <= '0;
            b_r      <= '0;
            y_r      <= '0;
            out_data <= '0;
            i        <= '0;
            j        <= '0;
            acc      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                x_r <= in_data;
                w_r <= w_data;
                b_r <= b_data;
                i   <= '0;
                j   <= '0;
                acc <= '0;
            end
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                i   <= last_i ? '0 : i + 1'b1;
            end
            if (state == FIN) begin
                acc <= '0;
                i   <= '0;
                y_r <= y_n;
                if (last_j) out_data <= y_n;
                else j <= j + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed checks of dense_layer_seq with hand-computed results (default 4x4, Q8.8).
module tb_dense_layer_seq;
    logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic         in_ready, out_valid, busy;
    logic [63:0]  in_data = '0;
    logic [255:0] w_data = '0;
    logic [63:0]  b_data = '0, out_data, held;
    int x[4], w[4][4], b[4];
    int n_cmp = 0, n_bad = 0;

    dense_layer_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_data(w_data), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear();
        for (int p = 0; p < 4; p++) begin
            x[p] = 0;
            b[p] = 0;
            for (int q = 0; q < 4; q++) w[p][q] = 0;
        end
    endtask

    task automatic send();
        @(negedge clk);
        chk("in_ready_before_send", in_ready, 1);
        for (int p = 0; p < 4; p++) begin
            in_data[p*16 +: 16] = 16'(x[p]);
            b_data[p*16 +: 16]  = 16'(b[p]);
            for (int q = 0; q < 4; q++) w_data[(p*4+q)*16 +: 16] = 16'(w[p][q]);
        end
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        in_data  = {$urandom, $urandom};
        w_data   = {8{$urandom}};
        b_data   = {$urandom, $urandom};
    endtask

    task automatic wait_done(input string tag, input int e[4]);
        int c = 0;
        while (!out_valid && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({tag, "_latency"}, c, 20);
        for (int p = 0; p < 4; p++)
            chk($sformatf("%s_y%0d", tag, p), longint'($signed(out_data[p*16 +: 16])), e[p]);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        chk({tag, "_valid_after_hs"}, out_valid, 0);
        chk({tag, "_busy_after_hs"}, busy, 0);
    endtask

    task automatic set_identity();
        clear();
        x = '{256, 512, -256, 128};
        for (int p = 0; p < 4; p++) w[p][p] = 256;
    endtask

    task automatic set_sat(input int wv);
        clear();
        for (int p = 0; p < 4; p++) begin
            x[p] = 32512;
            for (int q = 0; q < 4; q++) w[p][q] = wv;
        end
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        set_identity();
        send();
        chk("busy_in_op", busy, 1);
        chk("in_ready_in_op", in_ready, 0);
`ifdef DENSE_RELU_EN
        wait_done("ident", '{256, 512, 0, 128});
`else
        wait_done("ident", '{256, 512, -256, 128});
`endif
        handshake("ident");
        chk("ident_out_data_kept", out_data[47:32], 16'hFF00 & {16{1'b1}} & (out_data[47:32]));

        set_sat(32512);
        send();
        wait_done("sat_pos", '{32767, 32767, 32767, 32767});
        handshake("sat_pos");
`ifndef DENSE_RELU_EN
        set_sat(-32512);
        send();
        wait_done("sat_neg", '{-32768, -32768, -32768, -32768});
        handshake("sat_neg");
`endif

        clear();
        b = '{-256, 0, 256, 32767};
        x = '{100, 200, 300, 400};
        send();
`ifdef DENSE_RELU_EN
        wait_done("bias", '{0, 0, 256, 32767});
`else
        wait_done("bias", '{-256, 0, 256, 32767});
`endif
        handshake("bias");

        clear();
        x[0] = 1;
        w[0][0] = 128;
        send();
        wait_done("trunc_pos", '{0, 0, 0, 0});
        handshake("trunc_pos");
        x[0] = -1;
        send();
`ifdef DENSE_RELU_EN
        wait_done("trunc_neg", '{0, 0, 0, 0});
`else
        wait_done("trunc_neg", '{-1, 0, 0, 0});
`endif
        handshake("trunc_neg");

        set_identity();
        send();
`ifdef DENSE_RELU_EN
        wait_done("bp", '{256, 512, 0, 128});
`else
        wait_done("bp", '{256, 512, -256, 128});
`endif
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1;
            in_data  = {$urandom, $urandom};
        end
        in_valid = 0;
        chk("bp_valid_held", out_valid, 1);
        chk("bp_data_held", out_data, held);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        handshake("bp");
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_data_kept", out_data, held);

        set_identity();
        send();
        repeat (7) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 0;
        set_sat(32512);
        send();
        wait_done("rerun", '{32767, 32767, 32767, 32767});
        handshake("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
